// File: rtl/control_sequencer_pkg.sv
// Shared control-unit definitions for the mARC sequencer: state indices,
// instruction format codes, branch condition codes and PSR bit positions.
package control_sequencer_pkg;

  localparam int NSTATES = 13;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_OPERAND = 4'd2,
    S_ALU     = 4'd3,
    S_SHIFT   = 4'd4,
    S_MEM     = 4'd5,
    S_BR_ADDR = 4'd6,
    S_BR_EVAL = 4'd7,
    S_CALL    = 4'd8,
    S_SETHI   = 4'd9,
    S_LINK    = 4'd10,
    S_PC_INC  = 4'd11,
    S_TRAP    = 4'd12
  } state_idx_e;

  typedef enum logic [1:0] {
    FMT_BR    = 2'b00,
    FMT_CALL  = 2'b01,
    FMT_ARITH = 2'b10,
    FMT_MEM   = 2'b11
  } fmt_e;

  typedef enum logic [2:0] {
    COND_JMP = 3'b000,
    COND_BA  = 3'b001,
    COND_BNE = 3'b010,
    COND_BE  = 3'b011,
    COND_BG  = 3'b100,
    COND_BLE = 3'b101,
    COND_BGE = 3'b110,
    COND_BL  = 3'b111
  } cond_e;

  localparam int PSR_Z  = 0;
  localparam int PSR_N  = 1;
  localparam int PSR_V  = 2;
  localparam int PSR_C  = 3;
  localparam int PSR_TE = 4;

  // ir[13:11] pattern that selects the shifter path for arith instructions
  localparam logic [2:0] SHIFT_OP3 = 3'b111;

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle of the sequencer's instruction/status inputs, memory handshake and
// control outputs; master is the sequencer, slave is its environment.
interface control_sequencer_if
  import control_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic [15:0]         ir;
  logic [4:0]          status;
  logic                mem_ready;
  logic                irq;
  logic [NSTATES-1:0]  state;
  logic                ir_load;
  logic                mem_req;
  logic                trap_ack;
  logic [CNT_W-1:0]    instret;

  modport master (
    input  ir, status, mem_ready, irq,
    output state, ir_load, mem_req, trap_ack, instret
  );

  modport slave (
    output ir, status, mem_ready, irq,
    input  state, ir_load, mem_req, trap_ack, instret
  );

endinterface

// File: rtl/control_sequencer_branch_cond_eval.sv
// Combinational branch-condition evaluator: decides taken/not-taken from the
// 3-bit condition field and the Z/N/V flags.
module branch_cond_eval
  import control_sequencer_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [2:0] flags_i,
  output logic       taken
);

  logic z, lt;

  always_comb begin
    z     = flags_i[PSR_Z];
    // signed less-than after a compare is N xor V
    lt    = flags_i[PSR_N] ^ flags_i[PSR_V];
    taken = 1'b0;
    case (cond_e'(cond_i))
      COND_JMP: taken = 1'b1;
      COND_BA:  taken = 1'b1;
      COND_BNE: taken = ~z;
      COND_BE:  taken = z;
      COND_BG:  taken = ~z & ~lt;
      COND_BLE: taken = z | lt;
      COND_BGE: taken = ~lt;
      COND_BL:  taken = lt;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// One-hot control sequencer for the mARC control unit: state register,
// next-state decode and retired-instruction counter. Trap entry from PC_INC is
// built only when CONTROL_SEQ_TRAP_EN is defined.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int NSTATES = 13,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  control_sequencer_if.master  bus
);

  if (NSTATES != 13) begin : g_nstates_chk
    $error("control_sequencer: NSTATES must be 13");
  end

  logic [NSTATES-1:0] state_q, state_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  state_idx_e         nxt;
  logic               valid, taken, retire, trap_req;
  logic               unused_ok;

  branch_cond_eval u_branch_cond_eval (
    .cond_i  (bus.ir[10:8]),
    .flags_i (bus.status[2:0]),
    .taken   (taken)
  );

`ifdef CONTROL_SEQ_TRAP_EN
  logic trap_ack_q;

  assign trap_req  = bus.irq & bus.status[PSR_TE];
  assign unused_ok = ^{bus.ir[7:0], bus.status[PSR_C]};

  // first (and only) cycle in TRAP is the cycle after the registered entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trap_ack_q <= 1'b0;
    else     trap_ack_q <= state_d[S_TRAP];
  end

  assign bus.trap_ack = trap_ack_q;
`else
  assign trap_req     = 1'b0;
  assign unused_ok    = ^{bus.ir[7:0], bus.status[PSR_C], bus.status[PSR_TE], bus.irq};
  assign bus.trap_ack = 1'b0;
`endif

  always_comb begin
    state_d = '0;
    nxt     = S_FETCH;
    valid   = $onehot(state_q);
    if (valid) begin
      case (1'b1)
        state_q[S_FETCH]:   nxt = bus.mem_ready ? S_DECODE : S_FETCH;
        state_q[S_DECODE]: begin
          case (fmt_e'(bus.ir[15:14]))
            FMT_BR:   nxt = bus.ir[13] ? S_SETHI : S_BR_ADDR;
            FMT_CALL: nxt = S_CALL;
            default:  nxt = S_OPERAND;
          endcase
        end
        state_q[S_OPERAND]: begin
          if (fmt_e'(bus.ir[15:14]) == FMT_MEM)  nxt = S_MEM;
          else if (bus.ir[13:11] == SHIFT_OP3)   nxt = S_SHIFT;
          else                                   nxt = S_ALU;
        end
        state_q[S_ALU]:     nxt = S_PC_INC;
        state_q[S_SHIFT]:   nxt = S_PC_INC;
        state_q[S_MEM]:     nxt = bus.mem_ready ? S_PC_INC : S_MEM;
        state_q[S_BR_ADDR]: nxt = S_BR_EVAL;
        state_q[S_BR_EVAL]: nxt = taken ? S_FETCH : S_PC_INC;
        state_q[S_CALL]:    nxt = S_LINK;
        state_q[S_LINK]:    nxt = S_FETCH;
        state_q[S_SETHI]:   nxt = S_PC_INC;
        state_q[S_PC_INC]:  nxt = trap_req ? S_TRAP : S_FETCH;
        state_q[S_TRAP]:    nxt = S_FETCH;
        default:            nxt = S_FETCH;
      endcase
    end
    state_d[nxt] = 1'b1;

    // a corrupted (non-one-hot) state never counts as a retirement
    retire    = valid & (state_q[S_PC_INC] | state_q[S_LINK] |
                         (state_q[S_BR_EVAL] & taken));
    instret_d = instret_q + CNT_W'(retire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= NSTATES'(1);
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign bus.state   = state_q;
  assign bus.mem_req = state_q[S_FETCH] | state_q[S_MEM];
  assign bus.ir_load = state_q[S_FETCH] & bus.mem_ready;
  assign bus.instret = instret_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer: an instruction-level
// model predicts the full state path, handshake outputs and retire count.
module tb_control_sequencer;

`ifdef CONTROL_SEQ_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_cnt = 16'h0000;

  always #5 clk = ~clk;

  control_sequencer_if #(.CNT_W(16)) bus ();

  control_sequencer #(.NSTATES(13), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Branch outcome as a signed/equality compare result: lt means N != V.
  function automatic bit ref_taken(input bit [2:0] c, input bit z, input bit n, input bit v);
    bit lt;
    lt = (n != v);
    case (c)
      3'd0, 3'd1: return 1'b1;
      3'd2:       return !z;
      3'd3:       return z;
      3'd4:       return !(z || lt);
      3'd5:       return z || lt;
      3'd6:       return !lt;
      default:    return lt;
    endcase
  endfunction

  // Expected list of visited states (numbers 0..12) for one whole instruction.
  function automatic void build_path(input logic [15:0] i_ir, input logic [4:0] st,
                                     input bit i_irq, input int fw, input int mw,
                                     output int path[$]);
    bit to_pcinc;
    path = {};
    for (int k = 0; k <= fw; k++) path.push_back(0);
    path.push_back(1);
    to_pcinc = 1'b1;
    case (i_ir[15:14])
      2'b00: begin
        if (i_ir[13]) path.push_back(9);
        else begin
          path.push_back(6);
          path.push_back(7);
          if (ref_taken(i_ir[10:8], st[0], st[1], st[2])) to_pcinc = 1'b0;
        end
      end
      2'b01: begin
        path.push_back(8);
        path.push_back(10);
        to_pcinc = 1'b0;
      end
      2'b10: begin
        path.push_back(2);
        path.push_back((i_ir[13:11] == 3'b111) ? 4 : 3);
      end
      default: begin
        path.push_back(2);
        for (int k = 0; k <= mw; k++) path.push_back(5);
      end
    endcase
    if (to_pcinc) begin
      path.push_back(11);
      if (TRAP_EN && i_irq && st[4]) path.push_back(12);
    end
  endfunction

  // Runs one instruction from S0 and checks every cycle; leaves the DUT in S0.
  task automatic run_instr(input logic [15:0] i_ir, input logic [4:0] st,
                           input bit i_irq, input int fw, input int mw);
    int  path[$];
    int  fcnt, mcnt, e;
    bit  mr;
    build_path(i_ir, st, i_irq, fw, mw, path);
    fcnt = 0;
    mcnt = 0;
    foreach (path[k]) begin
      e = path[k];
      if (e == 0)      begin mr = (fcnt == fw); fcnt++; end
      else if (e == 5) begin mr = (mcnt == mw); mcnt++; end
      else             mr = 1'($urandom);
      bus.ir        = i_ir;
      bus.status    = st;
      bus.irq       = (e == 11) ? i_irq : 1'($urandom);
      bus.mem_ready = mr;
      #1;
      check_eq("state",    32'(bus.state),    32'(13'h1 << e));
      check_eq("mem_req",  32'(bus.mem_req),  32'((e == 0) || (e == 5)));
      check_eq("ir_load",  32'(bus.ir_load),  32'((e == 0) && mr));
      check_eq("trap_ack", 32'(bus.trap_ack), 32'(e == 12));
      check_eq("instret_hold", 32'(bus.instret), 32'(exp_cnt));
      @(posedge clk);
      #1;
    end
    exp_cnt = exp_cnt + 16'd1;
    check_eq("end_state", 32'(bus.state),   32'h1);
    check_eq("instret",   32'(bus.instret), 32'(exp_cnt));
  endtask

  initial begin
    bus.ir        = 16'h0000;
    bus.status    = 5'h00;
    bus.irq       = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state",    32'(bus.state),    32'h1);
    check_eq("rst_trap_ack", 32'(bus.trap_ack), 32'h0);
    check_eq("rst_instret",  32'(bus.instret),  32'h0);
    check_eq("rst_mem_req",  32'(bus.mem_req),  32'h1);
    check_eq("rst_ir_load",  32'(bus.ir_load),  32'h1);
    rst = 1'b0;

    // Abandon a load stuck in S5 with an asynchronous reset
    bus.ir = 16'hC000;
    repeat (3) @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    check_eq("s5_reached", 32'(bus.state), 32'h0020);
    @(posedge clk);
    #1;
    check_eq("s5_wait", 32'(bus.state), 32'h0020);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_state", 32'(bus.state), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_rel_mem_req", 32'(bus.mem_req), 32'h1);
    check_eq("rst_rel_instret", 32'(bus.instret), 32'h0);

    // Directed: arith, load with 3 wait cycles, bne with Z=0 / Z=1
    run_instr(16'h8000, 5'h00, 1'b0, 0, 0);
    run_instr(16'hC000, 5'h00, 1'b0, 0, 3);
    run_instr(16'h0200, 5'h00, 1'b0, 0, 0);
    run_instr(16'h0200, 5'h01, 1'b0, 0, 0);

    // Every branch condition against every Z/N/V combination
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 8; f++)
        run_instr({5'b00000, 3'(c), 8'($urandom)}, {2'($urandom), 3'(f)}, 1'($urandom), 0, 0);

    // Interrupt at PC_INC with trap enable set and clear
    run_instr(16'h8000, 5'h10, 1'b1, 0, 0);
    run_instr(16'h8000, 5'h00, 1'b1, 0, 0);
    run_instr(16'h6000, 5'h10, 1'b1, 1, 0);

    // Counter wrap
    force dut.instret_q = 16'hFFFF;
    #1;
    release dut.instret_q;
    exp_cnt = 16'hFFFF;
    run_instr(16'h8000, 5'h00, 1'b0, 0, 0);

    // Corrupted state vector recovers to S0 without counting
    force dut.state_q = 13'h0003;
    #1;
    release dut.state_q;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bad_state_next", 32'(bus.state),   32'h1);
    check_eq("bad_state_cnt",  32'(bus.instret), 32'(exp_cnt));

    // Random instruction mix
    for (int n = 0; n < 200; n++)
      run_instr(16'($urandom), 5'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
